poly_voice_controller: RTL and testbench

POLY_VOICE_CONTROLLER -- requirements
Module: poly_voice_controller

---
 rtl/poly_voice_controller.sv | 204 ++++++++++++++++++++
 tb/tb_poly_voice_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_controller.sv
// poly_voice_controller: polyphonic voice allocator with per-voice phase/level oscillators and a mixer.
// Latency: a request sampled at edge S updates voices and accepted/dropped after S; wave_out follows after S+1.
// Backpressure: none; requests are one-cycle pulses, and a note_on with no usable voice is discarded and flagged.
// Ports: clk, reset (async, active-low); note_on/note_off with note and octave (the key), plus
//        phase_inc/amplitude sampled on note_on; mode and release_step act live; outputs are
//        voice_active (from state), accepted/dropped pulses and the registered signed wave_out.
module poly_voice_controller #(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 24,
   parameter int AMP_W      = 16,
   parameter int OUT_W      = 19
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    note_on,
   input  logic                    note_off,
   input  logic [3:0]              note,
   input  logic [2:0]              octave,
   input  logic [PHASE_W-1:0]      phase_inc,
   input  logic                    mode,
   input  logic [AMP_W-1:0]        amplitude,
   input  logic [AMP_W-1:0]        release_step,
   output logic [NUM_VOICES-1:0]   voice_active,
   output logic                    accepted,
   output logic                    dropped,
   output logic signed [OUT_W-1:0] wave_out
);

   localparam int KEY_W  = 7;
   localparam int PROD_W = 2 * AMP_W + 2;

   typedef enum logic [1:0] {
      V_IDLE    = 2'd0,
      V_PLAY    = 2'd1,
      V_RELEASE = 2'd2
   } voice_state_t;

   voice_state_t         state_q [NUM_VOICES];
   voice_state_t         state_d [NUM_VOICES];
   logic [KEY_W-1:0]     key_q   [NUM_VOICES];
   logic [KEY_W-1:0]     key_d   [NUM_VOICES];
   logic [PHASE_W-1:0]   inc_q   [NUM_VOICES];
   logic [PHASE_W-1:0]   inc_d   [NUM_VOICES];
   logic [PHASE_W-1:0]   phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]   phase_d [NUM_VOICES];
   logic [AMP_W-1:0]     level_q [NUM_VOICES];
   logic [AMP_W-1:0]     level_d [NUM_VOICES];

   // Low until the first edge after reset release, so requests on that edge are ignored.
   logic                  req_en;
   logic [KEY_W-1:0]      req_key;
   logic                  on_req;
   logic                  off_req;
   logic [NUM_VOICES-1:0] hit_sel;
   logic [NUM_VOICES-1:0] idle_sel;
   logic [NUM_VOICES-1:0] rel_sel;
   logic [NUM_VOICES-1:0] alloc_sel;
   logic [NUM_VOICES-1:0] off_sel;
   logic                  accept_d;
   logic                  drop_d;
   logic signed [OUT_W-1:0] mix_d;

   assign req_key = {note, octave};
   assign on_req  = note_on & req_en;
   // note_on and note_off share one key input, so a coincident pair always names the same
   // key and the retrigger takes precedence over the release.
   assign off_req = note_off & req_en & ~note_on;

   // Voice selection from the current states; each *_sel vector keeps only its lowest-index candidate.
   always_comb begin
      hit_sel   = '0;
      idle_sel  = '0;
      rel_sel   = '0;
      alloc_sel = '0;
      off_sel   = '0;
      accept_d  = 1'b0;
      drop_d    = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (state_q[i] != V_IDLE && key_q[i] == req_key && !(|hit_sel))
            hit_sel[i] = 1'b1;
         if (state_q[i] == V_IDLE && !(|idle_sel))
            idle_sel[i] = 1'b1;
         if (state_q[i] == V_RELEASE && !(|rel_sel))
            rel_sel[i] = 1'b1;
         if (state_q[i] == V_PLAY && key_q[i] == req_key)
            off_sel[i] = off_req;
      end
      if (on_req) begin
         if (|hit_sel)
            alloc_sel = hit_sel;
         else if (|idle_sel)
            alloc_sel = idle_sel;
         else if (|rel_sel)
            alloc_sel = rel_sel;
      end
      accept_d = |alloc_sel;
      drop_d   = on_req & ~(|alloc_sel);
   end

   // Per-voice next state: allocation overrides whatever the voice was doing.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         state_d[i] = state_q[i];
         key_d[i]   = key_q[i];
         inc_d[i]   = inc_q[i];
         phase_d[i] = phase_q[i];
         level_d[i] = level_q[i];
         if (alloc_sel[i]) begin
            state_d[i] = V_PLAY;
            key_d[i]   = req_key;
            inc_d[i]   = phase_inc;
            phase_d[i] = '0;
            level_d[i] = amplitude;
         end else begin
            case (state_q[i])
               V_PLAY: begin
                  phase_d[i] = phase_q[i] + inc_q[i];
                  if (off_sel[i])
                     state_d[i] = V_RELEASE;
               end
               V_RELEASE: begin
                  if (level_q[i] == '0) begin
                     state_d[i] = V_IDLE;
                     key_d[i]   = '0;
                     inc_d[i]   = '0;
                     phase_d[i] = '0;
                     level_d[i] = '0;
                  end else begin
                     phase_d[i] = phase_q[i] + inc_q[i];
                     level_d[i] = (level_q[i] > release_step) ? (level_q[i] - release_step) : '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Mixer: square is +/-level on the phase MSB; saw scales the top AMP_W+1 phase bits
   // (as a signed ramp) by level and drops AMP_W fraction bits with an arithmetic shift.
   always_comb begin
      logic signed [AMP_W:0]  contrib;
      logic signed [AMP_W:0]  lvl_s;
      logic signed [PROD_W-1:0] s_ext;
      logic signed [PROD_W-1:0] l_ext;
      logic signed [PROD_W-1:0] saw_prod;
      mix_d    = '0;
      contrib  = '0;
      lvl_s    = '0;
      s_ext    = '0;
      l_ext    = '0;
      saw_prod = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         lvl_s    = $signed({1'b0, level_q[i]});
         s_ext    = PROD_W'($signed(phase_q[i][PHASE_W-1 -: AMP_W+1]));
         l_ext    = PROD_W'(lvl_s);
         saw_prod = s_ext * l_ext;
         if (state_q[i] == V_IDLE)
            contrib = '0;
         else if (mode)
            contrib = (AMP_W+1)'(saw_prod >>> AMP_W);
         else if (phase_q[i][PHASE_W-1])
            contrib = -lvl_s;
         else
            contrib = lvl_s;
         mix_d = mix_d + OUT_W'(contrib);
      end
   end

   always_comb begin
      voice_active = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         voice_active[i] = (state_q[i] != V_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_en   <= 1'b0;
         accepted <= 1'b0;
         dropped  <= 1'b0;
         wave_out <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            state_q[i] <= V_IDLE;
            key_q[i]   <= '0;
            inc_q[i]   <= '0;
            phase_q[i] <= '0;
            level_q[i] <= '0;
         end
      end else begin
         req_en   <= 1'b1;
         accepted <= accept_d;
         dropped  <= drop_d;
         wave_out <= mix_d;
         for (int i = 0; i < NUM_VOICES; i++) begin
            state_q[i] <= state_d[i];
            key_q[i]   <= key_d[i];
            inc_q[i]   <= inc_d[i];
            phase_q[i] <= phase_d[i];
            level_q[i] <= level_d[i];
         end
      end
   end

endmodule

// File: tb/tb_poly_voice_controller.sv
// tb_poly_voice_controller: directed stimulus for poly_voice_controller with a behavioural voice model.
// Latency: model predicts outputs one edge ahead, exactly as the registered outputs appear.
// Backpressure: not applicable; every cycle with reset high is compared.
module tb_poly_voice_controller;

   localparam int NV = 4;
   localparam int PW = 24;
   localparam int AW = 16;
   localparam int OW = 19;

   logic          clk          = 1'b0;
   logic          reset        = 1'b0;
   logic          note_on      = 1'b0;
   logic          note_off     = 1'b0;
   logic [3:0]    note         = '0;
   logic [2:0]    octave       = '0;
   logic [PW-1:0] phase_inc    = '0;
   logic          mode         = 1'b0;
   logic [AW-1:0] amplitude    = '0;
   logic [AW-1:0] release_step = '0;
   logic [NV-1:0] voice_active;
   logic          accepted;
   logic          dropped;
   logic [OW-1:0] wave_out;

   int vectors     = 0;
   int miscompares = 0;

   poly_voice_controller #(
      .NUM_VOICES(NV), .PHASE_W(PW), .AMP_W(AW), .OUT_W(OW)
   ) dut (
      .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
      .note(note), .octave(octave), .phase_inc(phase_inc), .mode(mode),
      .amplitude(amplitude), .release_step(release_step),
      .voice_active(voice_active), .accepted(accepted), .dropped(dropped),
      .wave_out(wave_out)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model: 0 idle, 1 playing, 2 releasing ----------------
   int m_st  [NV];
   int m_key [NV];
   int m_inc [NV];
   int m_ph  [NV];
   int m_lvl [NV];
   int exp_wave = 0;
   int exp_acc  = 0;
   int exp_drop = 0;
   bit armed    = 1'b0;

   function automatic int contrib(input int v, input logic md);
      longint s;
      longint p;
      if (m_st[v] == 0) return 0;
      if (!md) return (m_ph[v] >= 8388608) ? -m_lvl[v] : m_lvl[v];
      s = longint'(m_ph[v] / 128);          // top 17 bits of a 24-bit phase
      if (s >= 65536) s = s - 131072;        // read them as two's complement
      p = s * longint'(m_lvl[v]);
      return int'(p >>> 16);
   endfunction

   always @(posedge clk or negedge reset) begin : model
      int  w;
      int  tgt;
      int  off_t;
      int  key;
      bit  on;
      bit  off;
      if (!reset) begin
         for (int v = 0; v < NV; v++) begin
            m_st[v] = 0; m_key[v] = 0; m_inc[v] = 0; m_ph[v] = 0; m_lvl[v] = 0;
         end
         exp_wave = 0; exp_acc = 0; exp_drop = 0; armed = 1'b0;
      end else begin
         key   = int'({note, octave});
         on    = armed && note_on;
         off   = armed && note_off && !note_on;   // same key on both: the note_on prevails
         armed = 1'b1;
         w = 0;
         for (int v = 0; v < NV; v++) w = w + contrib(v, mode);
         exp_wave = w;
         tgt = -1;
         if (on) begin
            for (int v = 0; v < NV; v++) if (tgt < 0 && m_st[v] != 0 && m_key[v] == key) tgt = v;
            for (int v = 0; v < NV; v++) if (tgt < 0 && m_st[v] == 0) tgt = v;
            for (int v = 0; v < NV; v++) if (tgt < 0 && m_st[v] == 2) tgt = v;
         end
         off_t = -1;
         if (off)
            for (int v = 0; v < NV; v++) if (off_t < 0 && m_st[v] == 1 && m_key[v] == key) off_t = v;
         exp_acc  = (on && tgt >= 0) ? 1 : 0;
         exp_drop = (on && tgt < 0) ? 1 : 0;
         for (int v = 0; v < NV; v++) begin
            if (m_st[v] == 1) begin
               m_ph[v] = (m_ph[v] + m_inc[v]) % 16777216;
            end else if (m_st[v] == 2) begin
               if (m_lvl[v] == 0) begin
                  m_st[v] = 0; m_key[v] = 0; m_inc[v] = 0; m_ph[v] = 0;
               end else begin
                  m_ph[v]  = (m_ph[v] + m_inc[v]) % 16777216;
                  m_lvl[v] = (m_lvl[v] > int'(release_step)) ? m_lvl[v] - int'(release_step) : 0;
               end
            end
         end
         if (off_t >= 0) m_st[off_t] = 2;
         if (tgt >= 0) begin
            m_st[tgt] = 1; m_key[tgt] = key; m_inc[tgt] = int'(phase_inc);
            m_ph[tgt] = 0; m_lvl[tgt] = int'(amplitude);
         end
      end
   end

   task automatic check(input string name, input logic signed [31:0] actual,
                        input logic signed [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin : compare
      int act;
      if (reset) begin
         act = 0;
         for (int v = 0; v < NV; v++) if (m_st[v] != 0) act = act | (1 << v);
         check("cmp_voice_active", 32'(voice_active), act);
         check("cmp_accepted", 32'(accepted), exp_acc);
         check("cmp_dropped", 32'(dropped), exp_drop);
         check("cmp_wave_out", 32'($signed(wave_out)), exp_wave);
      end
   end

   // ---------------- stimulus ----------------
   int         sq_exp  [6] = '{0, 1000, 1000, -1000, -1000, 1000};
   int         rel_exp [5] = '{4000, 3750, 3500, 3250, 3000};
   logic [3:0] fill_keys [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_on(input logic [3:0] n, input logic [2:0] o,
                        input logic [PW-1:0] inc, input logic [AW-1:0] amp);
      note = n; octave = o; phase_inc = inc; amplitude = amp; note_on = 1'b1;
      tick();
      note_on = 1'b0;
   endtask

   task automatic do_off(input logic [3:0] n, input logic [2:0] o);
      note = n; octave = o; note_off = 1'b1;
      tick();
      note_off = 1'b0;
   endtask

   task automatic do_both(input logic [3:0] n, input logic [2:0] o,
                          input logic [PW-1:0] inc, input logic [AW-1:0] amp);
      note = n; octave = o; phase_inc = inc; amplitude = amp;
      note_on = 1'b1; note_off = 1'b1;
      tick();
      note_on = 1'b0; note_off = 1'b0;
   endtask

   // Asserts reset between edges, checks the outputs cleared without a clock, then releases it.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #2;
      check({tag, "_rst_active"}, 32'(voice_active), 0);
      check({tag, "_rst_wave"}, 32'($signed(wave_out)), 0);
      check({tag, "_rst_accepted"}, 32'(accepted), 0);
      check({tag, "_rst_dropped"}, 32'(dropped), 0);
      tick();
      reset = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      // power-on reset state, and a note_on held across the release edge is ignored
      #2;
      check("por_active", 32'(voice_active), 0);
      check("por_wave", 32'($signed(wave_out)), 0);
      check("por_accepted", 32'(accepted), 0);
      check("por_dropped", 32'(dropped), 0);
      note = 4'd5; octave = 3'd4; phase_inc = 24'h400000; amplitude = 16'd1000;
      note_on = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      note_on = 1'b0;
      check("release_edge_ignored_active", 32'(voice_active), 0);
      check("release_edge_ignored_acc", 32'(accepted), 0);
      tick();

      // square wave, key (5,4), period 4
      mode = 1'b0; release_step = '0;
      do_on(4'd5, 3'd4, 24'h400000, 16'd1000);
      check("sq_accepted", 32'(accepted), 1);
      check("sq_active", 32'(voice_active), 1);
      for (int k = 0; k < 6; k++) begin
         check("sq_wave", 32'($signed(wave_out)), sq_exp[k]);
         tick();
      end

      // fill all voices, fifth note is dropped
      do_reset("fill");
      for (int k = 0; k < 5; k++) begin
         do_on(fill_keys[k], 3'd0, 24'd0, 16'd1000);
         if (k < 4) begin
            check("fill_accepted", 32'(accepted), 1);
            check("fill_active", 32'(voice_active), (1 << (k + 1)) - 1);
         end else begin
            check("fill_dropped", 32'(dropped), 1);
            check("fill_not_accepted", 32'(accepted), 0);
            check("fill_active_full", 32'(voice_active), 15);
         end
      end

      // release voice 1 at 250 per cycle
      release_step = 16'd250;
      do_off(4'd2, 3'd0);
      check("rel_active_start", 32'(voice_active), 15);
      check("rel_wave_start", 32'($signed(wave_out)), 4000);
      for (int j = 0; j < 5; j++) begin
         tick();
         check("rel_wave", 32'($signed(wave_out)), rel_exp[j]);
      end
      check("rel_active_end", 32'(voice_active), 13);

      // idle voice preferred over a held release; steal only when none idle
      release_step = '0;
      do_off(4'd3, 3'd0);
      do_on(4'd7, 3'd1, 24'd0, 16'd1000);
      check("alloc_idle_first_acc", 32'(accepted), 1);
      check("alloc_idle_first_active", 32'(voice_active), 15);
      do_on(4'd8, 3'd1, 24'd0, 16'd1000);
      check("steal_acc", 32'(accepted), 1);
      check("steal_active", 32'(voice_active), 15);
      do_on(4'd9, 3'd1, 24'd0, 16'd1000);
      check("nosteal_dropped", 32'(dropped), 1);
      tick();
      check("steal_wave", 32'($signed(wave_out)), 4000);

      // coincident note_on/note_off on the same key: retrigger, stays playing
      release_step = 16'd250;
      do_both(4'd1, 3'd0, 24'd0, 16'd500);
      check("both_accepted", 32'(accepted), 1);
      check("both_dropped", 32'(dropped), 0);
      for (int k = 0; k < 4; k++) tick();
      check("both_wave_held", 32'($signed(wave_out)), 3500);
      check("both_active", 32'(voice_active), 15);

      // note_off with no matching key: nothing happens
      do_off(4'd15, 3'd7);
      check("off_nomatch_acc", 32'(accepted), 0);
      check("off_nomatch_drop", 32'(dropped), 0);
      tick();
      check("off_nomatch_active", 32'(voice_active), 15);

      // reset asserted while one of three voices is releasing
      do_reset("pre3");
      release_step = 16'd10;
      do_on(4'd1, 3'd1, 24'h200000, 16'd1000);
      do_on(4'd2, 3'd1, 24'h200000, 16'd1000);
      do_on(4'd3, 3'd1, 24'h200000, 16'd1000);
      do_off(4'd2, 3'd1);
      tick();
      tick();
      check("mid_release_active", 32'(voice_active), 7);
      do_reset("midrel");

      // sawtooth ramp, 16-cycle period
      mode = 1'b1; release_step = '0;
      do_on(4'd0, 3'd2, 24'h100000, 16'h8000);
      check("saw_accepted", 32'(accepted), 1);
      check("saw_wave_first", 32'($signed(wave_out)), 0);
      for (int k = 0; k <= 16; k++) begin
         tick();
         check("saw_wave", 32'($signed(wave_out)), (k < 8) ? 4096 * k : 4096 * k - 65536);
      end

      // live mode change back to square on the running voice
      mode = 1'b0;
      for (int k = 0; k < 6; k++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: still running at %0t, required to finish before 200000", $time);
      $fatal(1);
   end

endmodule
